rstgen: RTL and testbench

Reset sequencer sitting directly downstream of the PLL clock generator. Synchronises the PLL `locked` flag into the `sys_clk` domain and waits for it to be stable. It then releases the domain resets in a fixed order: SDRAM controller first, then system fabric, then the 68040 `RSTI`. Any loss of lock re-asserts every reset and restarts the sequence.

---
 rtl/rstgen.sv | 115 +++++++++++
 tb/tb_rstgen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/rstgen.sv
// rstgen: PLL-lock reset sequencer releasing sdram_rst, then sys_rst, then cpu_rst_n/ready.
// Define RSTGEN_TIMEOUT_EN to re-pulse sdram_rst and count retries when SDRAM init stalls.
module rstgen #(
    parameter int SETTLE_CYCLES = 1024,
    parameter int CPU_DELAY     = 256,
    parameter int INIT_TIMEOUT  = 65536
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       sdram_init_done,
    output logic       sdram_rst,
    output logic       sys_rst,
    output logic       cpu_rst_n,
    output logic       ready,
    output logic       lock_lost,
    output logic [3:0] retry_cnt
);
    localparam logic [2:0] WAIT_LOCK  = 3'd0;
    localparam logic [2:0] SETTLE     = 3'd1;
    localparam logic [2:0] SDRAM_INIT = 3'd2;
    localparam logic [2:0] SYS_START  = 3'd3;
    localparam logic [2:0] RUN        = 3'd4;
    localparam int MAX_SC = SETTLE_CYCLES > CPU_DELAY ? SETTLE_CYCLES : CPU_DELAY;
`ifdef RSTGEN_TIMEOUT_EN
    localparam int MAX_N = MAX_SC > INIT_TIMEOUT ? MAX_SC : INIT_TIMEOUT;
`else
    localparam int MAX_N = MAX_SC;
`endif
    localparam int CW = MAX_N > 1 ? $clog2(MAX_N) : 1;
    localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CPU_END    = CW'(CPU_DELAY - 1);

    if (SETTLE_CYCLES < 1 || CPU_DELAY < 1 || INIT_TIMEOUT < 1) begin : g_bad_params
        $error("rstgen: cycle parameters must be at least 1");
    end

    logic          meta_q, meta_d, locked_s_q, locked_s_d;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sdram_rst_q, sdram_rst_d, sys_rst_q, sys_rst_d, run_q, run_d;
    logic          lock_lost_q, lock_lost_d, pulse;

    always_comb begin
        meta_d      = pll_locked;
        locked_s_d  = meta_q;
        lock_lost_d = lock_lost_q;
        pulse       = 1'b0;
        case (state_q)
            WAIT_LOCK:  state_d = locked_s_q ? SETTLE : WAIT_LOCK;
            SETTLE:     state_d = !locked_s_q ? WAIT_LOCK : (cnt_q == SETTLE_END ? SDRAM_INIT : SETTLE);
            SDRAM_INIT: state_d = sdram_init_done ? SYS_START : SDRAM_INIT;
            SYS_START:  state_d = cnt_q == CPU_END ? RUN : SYS_START;
            RUN:        state_d = RUN;
            default:    state_d = WAIT_LOCK;
        endcase
`ifdef RSTGEN_TIMEOUT_EN
        pulse = state_q == SDRAM_INIT && !sdram_init_done && cnt_q == CW'(INIT_TIMEOUT - 1);
`endif
        // Lock loss past SETTLE beats init-done, terminal counts and timeouts.
        if (!locked_s_q && state_q inside {SDRAM_INIT, SYS_START, RUN}) begin
            state_d     = WAIT_LOCK;
            pulse       = 1'b0;
            lock_lost_d = 1'b1;
        end
        cnt_d = (state_d != state_q || pulse || !(state_q inside {SETTLE, SDRAM_INIT, SYS_START}))
                ? '0 : cnt_q + 1'b1;
        sdram_rst_d = state_d inside {WAIT_LOCK, SETTLE} || pulse;
        sys_rst_d   = !(state_d inside {SYS_START, RUN});
        run_d       = state_d == RUN;
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            meta_q      <= 1'b0;
            locked_s_q  <= 1'b0;
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            sdram_rst_q <= 1'b1;
            sys_rst_q   <= 1'b1;
            run_q       <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            meta_q      <= meta_d;
            locked_s_q  <= locked_s_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sdram_rst_q <= sdram_rst_d;
            sys_rst_q   <= sys_rst_d;
            run_q       <= run_d;
            lock_lost_q <= lock_lost_d;
        end
    end

`ifdef RSTGEN_TIMEOUT_EN
    logic [3:0] retry_q, retry_d;

    always_comb retry_d = (pulse && retry_q != 4'hf) ? retry_q + 4'd1 : retry_q;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) retry_q <= 4'd0;
        else        retry_q <= retry_d;
    end

    assign retry_cnt = retry_q;
`else
    assign retry_cnt = 4'd0;
`endif

    assign sdram_rst = sdram_rst_q;
    assign sys_rst   = sys_rst_q;
    assign cpu_rst_n = run_q;
    assign ready     = run_q;
    assign lock_lost = lock_lost_q;
endmodule

// File: tb/tb_rstgen.sv
// tb_rstgen: directed scenarios plus randomized lock/init activity for rstgen,
// checked every cycle against a behavioural sequencer model and absolute edge timings.
module tb_rstgen;
    localparam int S = 8, C = 4, T = 16;
    localparam int P_WAIT = 0, P_SETTLE = 1, P_INIT = 2, P_SYS = 3, P_RUN = 4;
`ifdef RSTGEN_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic       sys_clk = 1'b0, rst_n = 1'b0, pll_locked = 1'b0, sdram_init_done = 1'b0;
    logic       sdram_rst, sys_rst, cpu_rst_n, ready, lock_lost;
    logic [3:0] retry_cnt;
    int         checks = 0, errors = 0, edge_n = 0;
    int         m_stage = P_WAIT, m_age = 0, m_retries = 0;
    bit         m_meta = 0, m_ls = 0, m_lost = 0, m_pulse = 0;

    rstgen #(.SETTLE_CYCLES(S), .CPU_DELAY(C), .INIT_TIMEOUT(T)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .pll_locked(pll_locked),
        .sdram_init_done(sdram_init_done), .sdram_rst(sdram_rst), .sys_rst(sys_rst),
        .cpu_rst_n(cpu_rst_n), .ready(ready), .lock_lost(lock_lost), .retry_cnt(retry_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic enter(input int stage);
        m_stage = stage;
        m_age   = 0;
    endtask

    // Reference behaviour, advanced once per rising edge with the inputs seen at that edge.
    task automatic model_step();
        bit ls;
        if (!rst_n) begin
            m_meta = 0; m_ls = 0; m_lost = 0; m_pulse = 0; m_retries = 0;
            enter(P_WAIT);
            return;
        end
        ls      = m_ls;
        m_ls    = m_meta;
        m_meta  = pll_locked;
        m_pulse = 0;
        if (!ls && m_stage >= P_INIT) begin
            m_lost = 1;
            enter(P_WAIT);
            return;
        end
        if (m_stage == P_WAIT) begin
            if (ls) enter(P_SETTLE);
        end else if (m_stage == P_SETTLE) begin
            if (!ls) enter(P_WAIT);
            else if (m_age == S - 1) enter(P_INIT);
            else m_age++;
        end else if (m_stage == P_INIT) begin
            if (sdram_init_done) enter(P_SYS);
            else if (TMO && m_age == T - 1) begin
                m_pulse   = 1;
                m_age     = 0;
                m_retries = m_retries < 15 ? m_retries + 1 : 15;
            end else m_age++;
        end else if (m_stage == P_SYS) begin
            if (m_age == C - 1) enter(P_RUN);
            else m_age++;
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        model_step();
        edge_n++;
        #1;
        chk1("sdram_rst", sdram_rst, m_stage <= P_SETTLE || m_pulse);
        chk1("sys_rst", sys_rst, m_stage < P_SYS);
        chk1("cpu_rst_n", cpu_rst_n, m_stage == P_RUN);
        chk1("ready", ready, m_stage == P_RUN);
        chk1("lock_lost", lock_lost, m_lost);
        chk32("retry_cnt", 32'(retry_cnt), 32'(m_retries));
        chk1("order_sys_before_sdram", !sys_rst && sdram_rst, 1'b0);
        chk1("order_cpu_before_sys", cpu_rst_n && sys_rst, 1'b0);
    endtask

    initial begin
        int e, f, l, pulses;
        repeat (3) tick();
        chk1("reset_sdram_rst", sdram_rst, 1'b1);
        chk1("reset_sys_rst", sys_rst, 1'b1);
        chk1("reset_cpu_rst_n", cpu_rst_n, 1'b0);
        chk1("reset_ready", ready, 1'b0);
        chk1("reset_lock_lost", lock_lost, 1'b0);
        chk32("reset_retry_cnt", 32'(retry_cnt), 32'd0);

        rst_n = 1'b1;
        tick();
        pll_locked = 1'b1;
        e = edge_n + 1;
        for (int i = 0; i < 40 && sdram_rst !== 1'b0; i++) tick();
        chk32("powerup_sdram_release_edge", 32'(edge_n), 32'(e + S + 2));
        repeat (2) tick();
        sdram_init_done = 1'b1;
        f = edge_n + 1;
        tick();
        chk1("powerup_sys_rst_at_F", sys_rst, 1'b0);
        for (int i = 0; i < 20 && ready !== 1'b1; i++) tick();
        chk32("powerup_ready_edge", 32'(edge_n), 32'(f + C));
        chk1("powerup_cpu_rst_n", cpu_rst_n, 1'b1);

        rst_n = 1'b0;
        sdram_init_done = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20 && !(m_stage == P_SETTLE && m_age == 5); i++) tick();
        pll_locked = 1'b0;
        repeat (2) tick();
        pll_locked = 1'b1;
        e = edge_n + 1;
        for (int i = 0; i < 40 && sdram_rst !== 1'b0; i++) tick();
        chk32("glitch_settle_restart_edge", 32'(edge_n), 32'(e + S + 2));
        chk1("glitch_lock_lost", lock_lost, 1'b0);

        pulses = 0;
        for (int i = 0; i < 16 * T + 8; i++) begin
            tick();
            if (sdram_rst === 1'b1) pulses++;
        end
        chk32("timeout_pulse_count", 32'(pulses), TMO ? 32'd16 : 32'd0);
        chk32("timeout_retry_saturated", 32'(retry_cnt), TMO ? 32'd15 : 32'd0);

        pll_locked = 1'b0;
        repeat (2) tick();
        sdram_init_done = 1'b1;
        tick();
        chk1("simul_sys_rst", sys_rst, 1'b1);
        chk1("simul_sdram_rst", sdram_rst, 1'b1);
        chk1("simul_lock_lost", lock_lost, 1'b1);

        pll_locked = 1'b1;
        for (int i = 0; i < 40 && ready !== 1'b1; i++) tick();
        chk1("relock_ready", ready, 1'b1);
        pll_locked = 1'b0;
        l = edge_n + 1;
        for (int i = 0; i < 10 && sdram_rst !== 1'b1; i++) tick();
        chk32("runloss_assert_edge", 32'(edge_n), 32'(l + 2));
        chk1("runloss_cpu_rst_n", cpu_rst_n, 1'b0);
        chk1("runloss_lock_lost", lock_lost, 1'b1);
        pll_locked = 1'b1;
        for (int i = 0; i < 40 && ready !== 1'b1; i++) tick();
        chk1("replay_ready", ready, 1'b1);
        chk1("replay_lock_lost_sticky", lock_lost, 1'b1);

        pll_locked = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        for (int i = 0; i < 40 && m_stage != P_SYS; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk1("midreset_sdram_rst", sdram_rst, 1'b1);
        chk1("midreset_sys_rst", sys_rst, 1'b1);
        chk1("midreset_cpu_rst_n", cpu_rst_n, 1'b0);
        chk1("midreset_lock_lost", lock_lost, 1'b0);
        chk32("midreset_retry_cnt", 32'(retry_cnt), 32'd0);

        for (int b = 0; b < 150; b++) begin
            pll_locked = 1'b1;
            repeat ($urandom_range(1, 40)) begin
                sdram_init_done = ($urandom_range(0, 5) == 0);
                tick();
            end
            pll_locked = 1'b0;
            repeat ($urandom_range(1, 4)) tick();
            if ($urandom_range(0, 15) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
